// File: rtl/single_cycle_mips_mc.sv
// Multi-cycle MIPS-I subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// with a 32x32 register file and a handshaked, active-low strobed data port.
module single_cycle_mips_mc #(
    parameter int          DMEM_AW  = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        IR_addr,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic               CEN,
    output logic               OEN,
    output logic               WEN,
    output logic [DMEM_AW-1:0] A,
    output logic [31:0]        Data2Mem,
    input  logic [31:0]        ReadDataMem,
    input  logic               mem_ready,
    output logic               halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [31:0]        rs_val_q, rs_val_d;
    logic [31:0]        rt_val_q, rt_val_d;
    logic [31:0]        res_q, res_d;
    logic [DMEM_AW-1:0] a_q, a_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Instruction fields of the latched instruction
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] simm, pc_plus4, br_tgt, j_tgt, mem_addr, alu;
    logic        legal;
    logic        unused_addr_bits;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4 + {simm[29:0], 2'b00};
    assign j_tgt    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign mem_addr = rs_val_q + simm;
    assign unused_addr_bits = ^mem_addr[31:DMEM_AW+2];

    // $0 is hard-wired to zero on the read side
    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : rf_q[idx];
    endfunction

    // Classify the latched instruction as supported or not
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // ALU for R-type and addi; add/sub wrap naturally at 32 bits
    always_comb begin
        alu = 32'd0;
        if (op == OP_ADDI) begin
            alu = rs_val_q + simm;
        end else begin
            case (funct)
                F_SLL:   alu = rt_val_q << shamt;
                F_SRL:   alu = rt_val_q >> shamt;
                F_ADD:   alu = rs_val_q + rt_val_q;
                F_SUB:   alu = rs_val_q - rt_val_q;
                F_AND:   alu = rs_val_q & rt_val_q;
                F_OR:    alu = rs_val_q | rt_val_q;
                F_SLT:   alu = {31'd0, $signed(rs_val_q) < $signed(rt_val_q)};
                default: alu = 32'd0;
            endcase
        end
    end

    // Sequencer next-state, datapath register updates and register-file write port
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        res_d    = res_q;
        a_d      = a_q;
        wdata_d  = wdata_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        case (state_q)
            S_FETCH: begin
                if (IR_valid) begin
                    ir_d    = IR;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rs_val_d = rf_read(rs);
                rt_val_d = rf_read(rt);
                state_d  = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_BEQ: pc_d = (rs_val_q == rt_val_q) ? br_tgt : pc_plus4;
                    OP_BNE: pc_d = (rs_val_q != rt_val_q) ? br_tgt : pc_plus4;
                    OP_J:   pc_d = j_tgt;
                    OP_JAL: begin
                        pc_d     = j_tgt;
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_plus4;
                    end
                    OP_LW, OP_SW: begin
                        if (mem_addr[1:0] != 2'b00) begin
                            state_d = S_HALT;
                        end else begin
                            a_d     = mem_addr[DMEM_AW+1:2];
                            wdata_d = (op == OP_SW) ? rt_val_q : wdata_q;
                            pc_d    = pc_plus4;
                            state_d = S_MEM;
                        end
                    end
                    default: begin
                        if (op == OP_RTYPE && funct == F_JR) begin
                            pc_d = rs_val_q;
                        end else begin
                            res_d   = alu;
                            pc_d    = pc_plus4;
                            state_d = S_WB;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        res_d   = ReadDataMem;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_RTYPE) ? rd : rt;
                rf_wdata = res_q;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            rs_val_q <= 32'd0;
            rt_val_q <= 32'd0;
            res_q    <= 32'd0;
            a_q      <= '0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            res_q    <= res_d;
            a_q      <= a_d;
            wdata_q  <= wdata_d;
        end
    end

    // Register file; writes to $0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Strobes decode straight from the state so reset releases them immediately
    assign CEN      = (state_q != S_MEM);
    assign OEN      = !(state_q == S_MEM && op == OP_LW);
    assign WEN      = !(state_q == S_MEM && op == OP_SW);
    assign halted   = (state_q == S_HALT);
    assign IR_addr  = pc_q;
    assign A        = a_q;
    assign Data2Mem = wdata_q;

endmodule

// File: tb/tb_single_cycle_mips_mc.sv
// Bench for single_cycle_mips_mc: instruction ROM and wait-state data memory
// models, store scoreboard, timing, branch, halt and reset scenarios.
module tb_single_cycle_mips_mc;

    localparam int AW = 7;

    logic          clk;
    logic          rst;
    logic [31:0]   IR_addr;
    logic [31:0]   IR;
    logic          IR_valid;
    logic          CEN, OEN, WEN;
    logic [AW-1:0] A;
    logic [31:0]   Data2Mem;
    logic [31:0]   ReadDataMem;
    logic          mem_ready;
    logic          halted;

    single_cycle_mips_mc #(.DMEM_AW(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .IR_addr(IR_addr), .IR(IR), .IR_valid(IR_valid),
        .CEN(CEN), .OEN(OEN), .WEN(WEN), .A(A), .Data2Mem(Data2Mem),
        .ReadDataMem(ReadDataMem), .mem_ready(mem_ready), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } store_t;

    store_t      exp_q[$];
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:127];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          first_cen_cyc = -1;
    int          strobe_cyc = 0;
    int          acc_idx = 0;
    int          acc_cyc = 0;
    int          wait_left = 0;
    bit          in_acc = 0;
    bit          long_wait = 0;
    logic [AW-1:0] acc_a;
    logic [31:0]   acc_d;

    always @* IR = imem[IR_addr[9:2]];
    assign ReadDataMem = dmem[A];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        logic [4:0] s, t, d, h;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0]; h = sh[4:0];
        return {6'h00, s, t, d, h, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic push_store(input logic [AW-1:0] a, input logic [31:0] d);
        store_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
    endtask

    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc++;
    end

    // Data memory model: programmable wait states, store checking against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            in_acc    = 1'b0;
        end else if (!CEN) begin
            strobe_cyc++;
            if (!in_acc) begin
                in_acc    = 1'b1;
                acc_a     = A;
                acc_d     = Data2Mem;
                acc_cyc   = 0;
                wait_left = long_wait ? 30 : ((acc_idx == 0) ? 2 : (acc_idx % 2));
                if (first_cen_cyc < 0) first_cen_cyc = cyc;
            end else begin
                check_val("mem_A_stable", {25'd0, A}, {25'd0, acc_a});
                check_val("mem_D_stable", Data2Mem, acc_d);
            end
            acc_cyc++;
            if (wait_left > 0) begin
                mem_ready = 1'b0;
                wait_left--;
            end else begin
                mem_ready = 1'b1;
                if (!WEN) begin
                    store_t e;
                    check_val("wr_OEN", {31'd0, OEN}, 32'd1);
                    check_val("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val("st_A", {25'd0, A}, {25'd0, e.a});
                        check_val("st_D", Data2Mem, e.d);
                    end
                    if (acc_idx == 0) check_val("wr0_mem_cycles", acc_cyc, 32'd3);
                    dmem[A] = Data2Mem;
                end else begin
                    check_val("rd_OEN", {31'd0, OEN}, 32'd0);
                end
                acc_idx++;
                in_acc = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    initial begin
        int snap;
        bit seen;
        rst       = 1'b1;
        IR_valid  = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 128; i++) dmem[i] = 32'd0;
        clear_imem();

        // Program 1: arithmetic, memory, branch and jump coverage
        imem[0]  = itype(6'h08, 0, 1, 16'd5);
        imem[1]  = itype(6'h08, 0, 2, 16'hFFFD);
        imem[2]  = rtype(1, 2, 3, 0, 6'h20);
        imem[3]  = rtype(2, 1, 4, 0, 6'h2A);
        imem[4]  = itype(6'h2B, 0, 3, 16'd8);
        imem[5]  = itype(6'h23, 0, 5, 16'd8);
        imem[6]  = itype(6'h2B, 0, 5, 16'd12);
        imem[7]  = itype(6'h2B, 0, 4, 16'd16);
        imem[8]  = itype(6'h08, 0, 0, 16'd7);
        imem[9]  = rtype(0, 0, 1, 0, 6'h20);
        imem[10] = itype(6'h2B, 0, 1, 16'd20);
        imem[11] = rtype(2, 3, 7, 0, 6'h22);
        imem[12] = itype(6'h2B, 0, 7, 16'd24);
        imem[13] = rtype(0, 2, 8, 4, 6'h00);
        imem[14] = itype(6'h2B, 0, 8, 16'd28);
        imem[15] = itype(6'h05, 1, 1, 16'd5);
        imem[16] = jtype(6'h03, 26'h20);
        imem[17] = rtype(0, 2, 9, 28, 6'h02);
        imem[18] = itype(6'h2B, 0, 9, 16'd36);
        imem[19] = itype(6'h04, 0, 0, 16'hFFFF);
        imem[32] = itype(6'h2B, 0, 31, 16'd32);
        imem[33] = rtype(31, 0, 0, 0, 6'h08);
        push_store(7'd2, 32'd2);
        push_store(7'd3, 32'd2);
        push_store(7'd4, 32'd1);
        push_store(7'd5, 32'd0);
        push_store(7'd6, 32'hFFFF_FFFB);
        push_store(7'd7, 32'hFFFF_FFD0);
        push_store(7'd8, 32'h0000_0044);
        push_store(7'd9, 32'h0000_000F);

        repeat (2) @(negedge clk);
        check_val("rst_IR_addr", IR_addr, 32'd0);
        check_val("rst_CEN", {31'd0, CEN}, 32'd1);
        check_val("rst_OEN", {31'd0, OEN}, 32'd1);
        check_val("rst_WEN", {31'd0, WEN}, 32'd1);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_A", {25'd0, A}, 32'd0);
        check_val("rst_Data2Mem", Data2Mem, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("sb_drained", exp_q.size(), 32'd0);
        check_val("first_mem_cycle", first_cen_cyc, 32'd19);

        for (int i = 0; i < 100 && IR_addr != 32'h4C; i++) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_val("beq_self_pc", IR_addr, 32'h4C);
        end
        check_val("prog1_not_halted", {31'd0, halted}, 32'd0);

        // Program 2: reset asserted while a load waits in MEM
        rst = 1'b1;
        clear_imem();
        imem[0]   = itype(6'h23, 0, 1, 16'd0);
        long_wait = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = !CEN;
        end
        check_val("mem_entered", {31'd0, seen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rstmem_CEN", {31'd0, CEN}, 32'd1);
        check_val("rstmem_OEN", {31'd0, OEN}, 32'd1);
        check_val("rstmem_WEN", {31'd0, WEN}, 32'd1);
        check_val("rstmem_pc", IR_addr, 32'd0);
        @(negedge clk);
        long_wait = 1'b0;

        // Program 3: misaligned load halts with no strobe, fetch stalls honoured
        clear_imem();
        imem[0]  = itype(6'h23, 0, 1, 16'd2);
        IR_valid = 1'b0;
        snap     = strobe_cyc;
        rst      = 1'b0;
        repeat (5) @(negedge clk);
        check_val("stall_not_halted", {31'd0, halted}, 32'd0);
        check_val("stall_pc", IR_addr, 32'd0);
        IR_valid = 1'b1;
        for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
        check_val("misalign_halted", {31'd0, halted}, 32'd1);
        repeat (10) @(negedge clk);
        check_val("misalign_sticky", {31'd0, halted}, 32'd1);
        check_val("misalign_pc", IR_addr, 32'd0);
        check_val("misalign_no_strobe", strobe_cyc - snap, 32'd0);

        // Program 4: illegal opcode halts, reset clears the halt
        rst = 1'b1;
        #1;
        check_val("rst_clears_halt", {31'd0, halted}, 32'd0);
        clear_imem();
        imem[0] = itype(6'h08, 0, 1, 16'd1);
        imem[1] = 32'hFC00_0000;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check_val("illegal_halted", {31'd0, halted}, 32'd1);
        check_val("illegal_pc", IR_addr, 32'd4);
        check_val("illegal_CEN", {31'd0, CEN}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/single_cycle_mips_mc.md
SINGLE_CYCLE_MIPS_MC -- requirements
Module: single_cycle_mips_mc

Interface
REQ-001 SHALL provide parameter DMEM_AW, default 7, meaning data-memory word-address width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port IR_addr  output  32  instruction fetch address (current PC).
REQ-006 SHALL provide port IR  input  32  instruction word returned for IR_addr.
REQ-007 SHALL provide port IR_valid  input  1  IR holds the word for IR_addr this cycle.
REQ-008 SHALL provide port CEN  output  1  data-memory chip enable, active-low.
REQ-009 SHALL provide port OEN  output  1  data-memory read enable, active-low.
REQ-010 SHALL provide port WEN  output  1  data-memory write enable, active-low.
REQ-011 SHALL provide port A  output  DMEM_AW  data-memory word address.
REQ-012 SHALL provide port Data2Mem  output  32  store data.
REQ-013 SHALL provide port ReadDataMem  input  32  load data.
REQ-014 SHALL provide port mem_ready  input  1  data-memory access completes this cycle.
REQ-015 SHALL provide port halted  output  1  core stopped on an illegal opcode or misaligned access.

Function
REQ-016 SHALL implement the FSM FETCH, DECODE, EXEC, MEM, WB, HALT, one state per cycle unless stalled.
REQ-017 FETCH SHALL hold while IR_valid=0, then latch IR into an internal instruction register and go to DECODE.
REQ-018 DECODE SHALL read Rs/Rt from a 32x32 register file into operand registers; any unsupported opcode/funct SHALL go to HALT.
REQ-019 SHALL support sll, srl, add, sub, and, or, slt, jr, j, jal, beq, bne, addi, lw, sw with MIPS-I encodings; add/sub/addi SHALL wrap modulo 2^32, and slt SHALL be a signed compare.
REQ-020 EXEC SHALL compute PC+4, branch target PC+4+(sext(imm)<<2), and jump target {PC+4[31:28],imm26,2'b00}.
REQ-021 Taken beq/bne, j, jal and jr SHALL load PC in EXEC and return to FETCH; branch/jump latency SHALL be 3 cycles at IR_valid=1.
REQ-022 jal SHALL write PC+4 to $31 in EXEC.
REQ-023 R-type and addi SHALL go EXEC->WB, with PC<=PC+4 in EXEC; latency SHALL be 4 cycles.
REQ-024 lw/sw SHALL go EXEC->MEM, with address = Rs+sext(imm) and A = addr[DMEM_AW+1:2].
REQ-025 If addr[1:0]!=0, lw/sw SHALL go to HALT without asserting any memory strobe.
REQ-026 In MEM: CEN=0; OEN=0 for lw; WEN=0 for sw; A and Data2Mem SHALL be held stable until mem_ready=1 is sampled.
REQ-027 lw SHALL capture ReadDataMem on the mem_ready edge and go to WB (5 cycles plus wait cycles); sw SHALL go to FETCH (4 cycles plus wait cycles).
REQ-028 Outside MEM, CEN, OEN and WEN SHALL all be 1.
REQ-029 WB SHALL write Rd (R-type) or Rt (addi/lw), then return to FETCH.
REQ-030 $0 SHALL always read 0, and writes to $0 SHALL be discarded.
REQ-031 Operands SHALL be read in DECODE after any prior WB, so no forwarding path is required.
REQ-032 HALT SHALL be sticky until rst: halted=1, PC frozen, no register or memory writes.
REQ-033 PC SHALL wrap modulo 2^32.
REQ-034 A branch offset of -1 SHALL re-execute the same instruction indefinitely.

Reset
REQ-035 rst=1 SHALL, asynchronously, set PC=RESET_PC, state=FETCH, all registers 0, CEN=OEN=WEN=1, halted=0, and A, Data2Mem and the internal instruction register to 0.
REQ-036 rst asserted during MEM SHALL release the strobes immediately; the pending access SHALL be abandoned and no writeback SHALL occur.
REQ-037 After rst deasserts, the first fetch SHALL occur at RESET_PC on the next rising edge.

Verification
REQ-038 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1; total 16 cycles at IR_valid=1.
REQ-039 sw $3,8($0) with mem_ready low for 2 cycles -> CEN=WEN=0, A=2, Data2Mem=2 for 3 cycles; then lw $5,8($0) -> $5=2.
REQ-040 beq $1,$1,-1 -> PC is unchanged every 3 cycles; bne $1,$1,x -> PC+4.
REQ-041 jal at PC=0x40 -> $31=0x44, PC=jump target; then jr $31 -> PC=0x44.
REQ-042 lw $1,2($0) -> halted=1 with no strobe asserted; illegal opcode 6'h3F -> halted=1; both stay halted until rst.
REQ-043 addi $0,$0,7 followed by add $1,$0,$0 -> $1=0; rst pulse mid-MEM -> PC=RESET_PC and strobes high within the same cycle.
